// File: rtl/saph_fpu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined FPU adder between
// several requesters; a {valid,id} tag pipeline routes each result back.
module saph_fpu_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int LATENCY    = 3,
  parameter int WIDTH      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQUESTERS-1:0]         req_valid,
  output logic [REQUESTERS-1:0]         req_ready,
  input  logic [REQUESTERS*WIDTH-1:0]   req_lhs,
  input  logic [REQUESTERS*WIDTH-1:0]   req_rhs,
  output logic [REQUESTERS-1:0]         resp_valid,
  output logic [WIDTH-1:0]              resp_data,
  input  logic                          drain,
  output logic                          idle,
  output logic                          fpu_trig,
  output logic [WIDTH-1:0]              fpu_lhs,
  output logic [WIDTH-1:0]              fpu_rhs,
  input  logic [WIDTH-1:0]              fpu_res
);
  localparam int IDW = $clog2(REQUESTERS);

  logic [IDW-1:0]                ptr_q, ptr_d;
  logic [IDW-1:0]                gnt_id;
  logic                          gnt_vld;
  logic [IDW:0]                  scan;
  logic [LATENCY-1:0]            vld_pipe_q, vld_pipe_d;
  logic [LATENCY-1:0][IDW-1:0]   id_pipe_q, id_pipe_d;

  // Scan from the pointer upward; scan never exceeds 2*REQUESTERS-2 so a
  // single conditional subtract is enough for the modulo.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    scan    = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      scan = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(REQUESTERS)) scan = scan - (IDW+1)'(REQUESTERS);
      if (!gnt_vld && !drain && req_valid[scan[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = scan[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready  = '0;
    fpu_lhs    = '0;
    fpu_rhs    = '0;
    resp_valid = '0;
    resp_data  = '0;
    if (gnt_vld) begin
      req_ready[gnt_id] = 1'b1;
      fpu_lhs = req_lhs[gnt_id*WIDTH +: WIDTH];
      fpu_rhs = req_rhs[gnt_id*WIDTH +: WIDTH];
    end
    if (vld_pipe_q[LATENCY-1]) begin
      resp_valid[id_pipe_q[LATENCY-1]] = 1'b1;
      resp_data = fpu_res;
    end
  end

  assign fpu_trig = gnt_vld;
  assign idle     = ~|vld_pipe_q;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (gnt_id == IDW'(REQUESTERS-1)) ? '0 : gnt_id + 1'b1;
    vld_pipe_d[0] = gnt_vld;
    id_pipe_d[0]  = gnt_id;
    for (int i = 1; i < LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      id_pipe_d[i]  = id_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      vld_pipe_q <= vld_pipe_d;
      id_pipe_q  <= id_pipe_d;
    end
  end
endmodule

// File: tb/tb_saph_fpu_arbiter.sv
// Bench: three arbiter configurations driven side by side against a
// queue-based scoreboard, plus directed scenarios on the 4-requester build.
module tb_saph_fpu_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  function automatic int rcfg(input int g);
    case (g)
      0: return 4;
      1: return 2;
      default: return 16;
    endcase
  endfunction

  function automatic int lcfg(input int g);
    case (g)
      0: return 3;
      1: return 1;
      default: return 5;
    endcase
  endfunction

  // Model FPU: single-precision add done through doubles (truncating)
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] da, db, dr;
    logic [10:0] e;
    real x;
    da = (a[30:0] == 0) ? 64'(0) : {a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'b0};
    db = (b[30:0] == 0) ? 64'(0) : {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'b0};
    x  = $bitstoreal(da) + $bitstoreal(db);
    dr = $realtobits(x);
    if (dr[62:0] == 0) return {dr[63], 31'b0};
    e = dr[62:52] - 11'd896;
    return {dr[63], e[7:0], dr[51:29]};
  endfunction

  logic [15:0]  rv_s   [3];
  logic [511:0] lhs_s  [3];
  logic [511:0] rhs_s  [3];
  logic         drain_s[3];
  logic         rst_s  [3];
  logic [15:0]  rr_s   [3];
  logic [15:0]  rsv_s  [3];
  logic [31:0]  rd_s   [3];
  logic [31:0]  fl_s   [3];
  logic [31:0]  fr_s   [3];
  logic         idle_s [3];
  logic         trig_s [3];

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int R = rcfg(g);
    localparam int L = lcfg(g);
    logic [R-1:0] rr_w, rsv_w;
    logic [31:0]  fres_w;
    logic [31:0]  fpipe [L];

    saph_fpu_arbiter #(.REQUESTERS(R), .LATENCY(L), .WIDTH(32)) u_dut (
      .clk(clk), .rst(rst_s[g]),
      .req_valid(rv_s[g][R-1:0]), .req_ready(rr_w),
      .req_lhs(lhs_s[g][R*32-1:0]), .req_rhs(rhs_s[g][R*32-1:0]),
      .resp_valid(rsv_w), .resp_data(rd_s[g]),
      .drain(drain_s[g]), .idle(idle_s[g]),
      .fpu_trig(trig_s[g]), .fpu_lhs(fl_s[g]), .fpu_rhs(fr_s[g]),
      .fpu_res(fres_w)
    );
    assign rr_s[g]  = 16'(rr_w);
    assign rsv_s[g] = 16'(rsv_w);

    // The FPU itself never resets; idle slots carry a poison value
    always @(posedge clk) begin
      fpipe[0] <= trig_s[g] ? fadd(fl_s[g], fr_s[g]) : 32'hDEADBEEF;
      for (int i = 1; i < L; i++) fpipe[i] <= fpipe[i-1];
    end
    assign fres_w = fpipe[L-1];
  end

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } ent_t;

  ent_t mq [3][$];
  int   ptr [3];

  function automatic void mgrant(input int g, output bit f, output int id);
    f  = 1'b0;
    id = 0;
    if (drain_s[g]) return;
    for (int k = 0; k < rcfg(g); k++) begin
      int j;
      j = (ptr[g] + k) % rcfg(g);
      if (rv_s[g][j]) begin
        f  = 1'b1;
        id = j;
        return;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    bit f;
    int id;
    for (int g = 0; g < 3; g++) begin
      if (rst_s[g]) begin
        mq[g].delete();
        ptr[g] = 0;
      end else begin
        if (mq[g].size() > 0 && mq[g][0].due == cyc) void'(mq[g].pop_front());
        mgrant(g, f, id);
        if (f) begin
          mq[g].push_back('{cyc + lcfg(g), id,
                            fadd(lhs_s[g][id*32 +: 32], rhs_s[g][id*32 +: 32])});
          ptr[g] = (id + 1) % rcfg(g);
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit          f;
    int          id;
    logic [15:0] e_rr, e_rsv;
    logic [31:0] e_fl, e_fr, e_rd;
    if (chk_en) begin
      for (int g = 0; g < 3; g++) begin
        if (!rst_s[g]) begin
          mgrant(g, f, id);
          e_rr = '0; e_fl = '0; e_fr = '0; e_rsv = '0; e_rd = '0;
          if (f) begin
            e_rr[id] = 1'b1;
            e_fl = lhs_s[g][id*32 +: 32];
            e_fr = rhs_s[g][id*32 +: 32];
          end
          if (mq[g].size() > 0 && mq[g][0].due == cyc) begin
            e_rsv[mq[g][0].id] = 1'b1;
            e_rd = mq[g][0].data;
          end
          chk($sformatf("cfg%0d req_ready", g), 32'(rr_s[g]), 32'(e_rr));
          chk($sformatf("cfg%0d fpu_trig", g), 32'(trig_s[g]), 32'(f));
          chk($sformatf("cfg%0d fpu_lhs", g), fl_s[g], e_fl);
          chk($sformatf("cfg%0d fpu_rhs", g), fr_s[g], e_fr);
          chk($sformatf("cfg%0d resp_valid", g), 32'(rsv_s[g]), 32'(e_rsv));
          chk($sformatf("cfg%0d resp_data", g), rd_s[g], e_rd);
          chk($sformatf("cfg%0d idle", g), 32'(idle_s[g]), 32'(mq[g].size() == 0));
        end
      end
    end
  end

  function automatic logic [31:0] rnd_f();
    return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  task automatic rand_cfg(input int g);
    logic [15:0] v;
    rst_s[g]   = ($urandom_range(0, 199) == 0);
    drain_s[g] = ($urandom_range(0, 9) == 0);
    v = 16'($urandom);
    if ($urandom_range(0, 2) == 0) v &= 16'($urandom);
    v &= 16'((32'h1 << rcfg(g)) - 1);
    rv_s[g] = rst_s[g] ? 16'h0 : v;
    for (int i = 0; i < 16; i++) begin
      lhs_s[g][i*32 +: 32] = rnd_f();
      rhs_s[g][i*32 +: 32] = rnd_f();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rand_cfg(1);
    rand_cfg(2);
  endtask

  task automatic drive0(input logic [3:0] v, input bit dr, input bit rs);
    rv_s[0] = 16'(v);
    drain_s[0] = dr;
    rst_s[0] = rs;
  endtask

  task automatic cyc0(input logic [3:0] v, input bit dr, input bit rs);
    step();
    drive0(v, dr, rs);
    @(negedge clk);
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst_s[g] = 1'b1;
      drain_s[g] = 1'b0;
      rv_s[g] = '0;
      for (int i = 0; i < 16; i++) begin
        lhs_s[g][i*32 +: 32] = rnd_f();
        rhs_s[g][i*32 +: 32] = rnd_f();
      end
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) rst_s[g] = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset idle", 32'(idle_s[0]), 32'd1);
    chk("reset req_ready", 32'(rr_s[0]), 32'd0);
    chk("reset resp_valid", 32'(rsv_s[0]), 32'd0);
    chk("reset fpu_trig", 32'(trig_s[0]), 32'd0);

    // Single requester: 1.0 + 2.0 on requester 2
    step();
    lhs_s[0][2*32 +: 32] = 32'h3F800000;
    rhs_s[0][2*32 +: 32] = 32'h40000000;
    drive0(4'b0100, 1'b0, 1'b0);
    @(negedge clk);
    chk("single req_ready", 32'(rr_s[0]), 32'h4);
    chk("single fpu_trig", 32'(trig_s[0]), 32'd1);
    chk("single fpu_lhs", fl_s[0], 32'h3F800000);
    cyc0(4'b0000, 1'b0, 1'b0);
    chk("single idle busy", 32'(idle_s[0]), 32'd0);
    cyc0(4'b0000, 1'b0, 1'b0);
    cyc0(4'b0000, 1'b0, 1'b0);
    chk("single resp_valid", 32'(rsv_s[0]), 32'h4);
    chk("single resp_data", rd_s[0], 32'h40400000);
    cyc0(4'b0000, 1'b0, 1'b0);
    chk("single idle after", 32'(idle_s[0]), 32'd1);

    // All four held valid from reset: strict rotation
    cyc0(4'b0000, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cyc0(4'b1111, 1'b0, 1'b0);
      chk($sformatf("rotate grant %0d", k), 32'(rr_s[0]), 32'(1) << (k % 4));
      if (k >= 3) chk($sformatf("rotate resp %0d", k), 32'(rsv_s[0]), 32'(1) << ((k - 3) % 4));
    end
    cyc0(4'b0000, 1'b0, 1'b0);

    // Pointer at 2 with requesters 1/3, then 0 joins after pointer wraps
    cyc0(4'b0000, 1'b0, 1'b1);
    begin
      logic [3:0] vs [6] = '{4'h3, 4'h3, 4'hA, 4'hB, 4'hB, 4'hB};
      logic [3:0] es [6] = '{4'h1, 4'h2, 4'h8, 4'h1, 4'h2, 4'h8};
      for (int k = 0; k < 6; k++) begin
        cyc0(vs[k], 1'b0, 1'b0);
        chk($sformatf("rr order %0d", k), 32'(rr_s[0]), 32'(es[k]));
      end
    end

    // Drain with two operations in flight
    cyc0(4'b0000, 1'b0, 1'b1);
    cyc0(4'b0001, 1'b0, 1'b0);
    chk("drain pre0", 32'(rr_s[0]), 32'h1);
    cyc0(4'b0010, 1'b0, 1'b0);
    chk("drain pre1", 32'(rr_s[0]), 32'h2);
    for (int k = 0; k < 4; k++) begin
      cyc0(4'b1111, 1'b1, 1'b0);
      chk($sformatf("drain no grant %0d", k), 32'(rr_s[0]), 32'h0);
      if (k == 1) chk("drain resp0", 32'(rsv_s[0]), 32'h1);
      if (k == 2) chk("drain resp1", 32'(rsv_s[0]), 32'h2);
      if (k == 2) chk("drain idle busy", 32'(idle_s[0]), 32'd0);
      if (k == 3) chk("drain idle", 32'(idle_s[0]), 32'd1);
    end
    cyc0(4'b1111, 1'b0, 1'b0);
    chk("drain resume", 32'(rr_s[0]), 32'h4);

    // Reset with two operations in flight
    cyc0(4'b0000, 1'b0, 1'b1);
    cyc0(4'b0001, 1'b0, 1'b0);
    cyc0(4'b0010, 1'b0, 1'b0);
    cyc0(4'b0000, 1'b0, 1'b1);
    cyc0(4'b1111, 1'b0, 1'b0);
    chk("midrst idle", 32'(idle_s[0]), 32'd1);
    chk("midrst ptr0", 32'(rr_s[0]), 32'h1);
    chk("midrst no resp a", 32'(rsv_s[0]), 32'h0);
    cyc0(4'b0000, 1'b0, 1'b0);
    chk("midrst no resp b", 32'(rsv_s[0]), 32'h0);

    // Randomized traffic on every configuration
    for (int n = 0; n < 3000; n++) begin
      step();
      rand_cfg(0);
    end

    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      rv_s[g] = '0;
      drain_s[g] = 1'b0;
      rst_s[g] = 1'b0;
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) chk($sformatf("cfg%0d final idle", g), 32'(idle_s[g]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
